// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between the core's memory controls and a req/ack SRAM port.
// Misaligned accesses become two aligned word beats; each beat is guarded by an ack timeout.
module lsu_mem_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int TIMEOUT  = 16,
    parameter int SPLIT_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_wren,
    input  logic [2:0]        i_num_byte,
    input  logic              i_in_sram,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_baddr,
    output logic [3:0]        o_bmask,
    output logic [31:0]       o_bwdata,
    input  logic              i_ack,
    input  logic [31:0]       i_rdata,
    output logic [31:0]       o_ld_data,
    output logic              o_ld_vld,
    output logic              o_en_pc,
    output logic              o_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_baddr;
    logic [3:0]        r_bmask;
    logic [31:0]       r_bwdata;
    logic [31:0]       r_ld_data;
    logic              r_ld_vld;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_off;
    logic [2:0]        r_size;
    logic              r_unsigned;
    logic              r_split;
    logic              r_store;
    logic [31:0]       r_wdata;
    logic [3:0]        r_mask_hi;
    logic [31:0]       r_lo;

    logic              w_req_next;
    logic              w_we_next;
    logic [ADDR_W-1:0] w_baddr_next;
    logic [3:0]        w_bmask_next;
    logic [31:0]       w_bwdata_next;
    logic [31:0]       w_ld_data_next;
    logic              w_ld_vld_next;
    logic              w_err_next;
    logic              w_en_pc;

    logic              w_acc;
    logic [1:0]        w_off;
    logic [2:0]        w_size;
    logic              w_unsigned;
    logic [3:0]        w_size_bits;
    logic [7:0]        w_mask8;
    logic              w_misal;
    logic              w_split;
    logic              w_in_beat;
    logic              w_ack_ok;
    logic              w_tmo;
    logic [5:0]        w_sh_hi;
    logic [63:0]       w_pair;
    logic [31:0]       w_word;
    logic [31:0]       w_ext;

    // Request decode; illegal sizes fall back to a full word.
    always_comb begin
        w_size      = 3'd4;
        w_unsigned  = 1'b1;
        w_size_bits = 4'b1111;
        case (i_num_byte)
            3'd0: begin w_size = 3'd1; w_unsigned = 1'b0; w_size_bits = 4'b0001; end
            3'd1: begin w_size = 3'd1; w_unsigned = 1'b1; w_size_bits = 4'b0001; end
            3'd2: begin w_size = 3'd2; w_unsigned = 1'b0; w_size_bits = 4'b0011; end
            3'd3: begin w_size = 3'd2; w_unsigned = 1'b1; w_size_bits = 4'b0011; end
            default: ;
        endcase
    end

    assign w_acc     = (i_mem_read | i_mem_wren) & i_in_sram;
    assign w_off     = i_addr[1:0];
    assign w_mask8   = {4'b0000, w_size_bits} << w_off;
    assign w_misal   = ((w_size == 3'd2) & w_off[0]) | ((w_size == 3'd4) & (w_off != 2'd0));
    assign w_split   = ({1'b0, w_off} + w_size) > 3'd4;

    assign w_in_beat = (r_state == S_BEAT0) || (r_state == S_BEAT1);
    // An ack only counts while the request is actually on the bus.
    assign w_ack_ok  = w_in_beat & i_ack & r_req;
    assign w_tmo     = w_in_beat & ~w_ack_ok & (r_cnt == CNT_LAST);
    assign w_sh_hi   = {3'd4 - {1'b0, r_off}, 3'b000};

    // Load merge: {hi,lo} shifted down by the byte offset, then extended.
    always_comb begin
        w_pair = (r_state == S_BEAT1) ? {i_rdata, r_lo} : {32'd0, i_rdata};
        w_word = 32'(w_pair >> {r_off, 3'b000});
        case (r_size)
            3'd1:    w_ext = r_unsigned ? {24'd0, w_word[7:0]}   : {{24{w_word[7]}}, w_word[7:0]};
            3'd2:    w_ext = r_unsigned ? {16'd0, w_word[15:0]}  : {{16{w_word[15]}}, w_word[15:0]};
            default: w_ext = w_word;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_next = (w_misal && (SPLIT_EN == 0)) ? S_ERR : S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (w_ack_ok) begin
                    w_state_next = r_split ? S_BEAT1 : S_DONE;
                end else if (w_tmo) begin
                    w_state_next = S_ERR;
                end
            end
            S_BEAT1: begin
                if (w_ack_ok) begin
                    w_state_next = S_DONE;
                end else if (w_tmo) begin
                    w_state_next = S_ERR;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_next     = r_req;
        w_we_next      = r_we;
        w_baddr_next   = r_baddr;
        w_bmask_next   = r_bmask;
        w_bwdata_next  = r_bwdata;
        w_ld_data_next = r_ld_data;
        w_ld_vld_next  = 1'b0;
        w_err_next     = (w_state_next == S_ERR) && (r_state != S_ERR);
        w_en_pc        = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_en_pc = ~w_acc;
                if (w_state_next == S_BEAT0) begin
                    w_req_next    = 1'b1;
                    w_we_next     = i_mem_wren;
                    w_baddr_next  = {i_addr[ADDR_W-1:2], 2'b00};
                    w_bmask_next  = w_mask8[3:0];
                    w_bwdata_next = i_mem_wren ? (i_wdata << {w_off, 3'b000}) : 32'd0;
                end
            end
            S_BEAT0, S_BEAT1: begin
                w_en_pc = 1'b0;
                if (w_ack_ok || w_tmo) begin
                    w_req_next = 1'b0;
                    w_we_next  = 1'b0;
                end else if (!r_req) begin
                    // Second beat raises its request one cycle after the first ack.
                    w_req_next = 1'b1;
                    w_we_next  = r_store;
                end
                if ((r_state == S_BEAT0) && (w_state_next == S_BEAT1)) begin
                    w_baddr_next  = r_baddr + ADDR_W'(4);
                    w_bmask_next  = r_mask_hi;
                    w_bwdata_next = r_store ? (r_wdata >> w_sh_hi) : 32'd0;
                end
                if ((w_state_next == S_DONE) && !r_store) begin
                    w_ld_vld_next  = 1'b1;
                    w_ld_data_next = w_ext;
                end
            end
            default: w_en_pc = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_baddr    <= '0;
            r_bmask    <= 4'd0;
            r_bwdata   <= 32'd0;
            r_ld_data  <= 32'd0;
            r_ld_vld   <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_off      <= 2'd0;
            r_size     <= 3'd0;
            r_unsigned <= 1'b0;
            r_split    <= 1'b0;
            r_store    <= 1'b0;
            r_wdata    <= 32'd0;
            r_mask_hi  <= 4'd0;
            r_lo       <= 32'd0;
        end else begin
            r_req     <= w_req_next;
            r_we      <= w_we_next;
            r_baddr   <= w_baddr_next;
            r_bmask   <= w_bmask_next;
            r_bwdata  <= w_bwdata_next;
            r_ld_data <= w_ld_data_next;
            r_ld_vld  <= w_ld_vld_next;
            r_err     <= w_err_next;
            r_cnt     <= (w_in_beat && !w_ack_ok && !w_tmo) ? r_cnt + CNT_W'(1) : '0;
            if ((r_state == S_IDLE) && w_acc) begin
                r_off      <= w_off;
                r_size     <= w_size;
                r_unsigned <= w_unsigned;
                r_split    <= w_split;
                r_store    <= i_mem_wren;
                r_wdata    <= i_wdata;
                r_mask_hi  <= w_mask8[7:4];
            end
            if ((r_state == S_BEAT0) && w_ack_ok) begin
                r_lo <= i_rdata;
            end
        end
    end

    assign o_req     = r_req;
    assign o_we      = r_we;
    assign o_baddr   = r_baddr;
    assign o_bmask   = r_bmask;
    assign o_bwdata  = r_bwdata;
    assign o_ld_data = r_ld_data;
    assign o_ld_vld  = r_ld_vld;
    assign o_err     = r_err;
    assign o_en_pc   = w_en_pc | ~i_rst_n;

endmodule
